mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Parametrised N-port memory request arbiter that merges several core-side memory ports onto the single-port interface of memory_controller. It generalises today's fixed 2-port memory wiring between cpu_core and memory_controller: port count, address and data widths are parameters. Arbitration is round-robin with at most one outstanding transaction. It sits between cpu_core (and future DMA/debug masters) and memory_controller in the cpu top level.

Parameters:
NPORTS, 2, number of upstream request ports (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width; DATA_W/8 mask bits

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
up_rw_flag  in  2*NPORTS  per-port request: 2'b01 read, 2'b10 write, 2'b00/2'b11 idle
up_addr  in  ADDR_W*NPORTS  per-port address
up_write_data  in  DATA_W*NPORTS  per-port write data
up_write_mask  in  (DATA_W/8)*NPORTS  per-port byte enables
up_read_data  out  DATA_W*NPORTS  per-port read data; slice updated only on that port's done
up_busy  out  NPORTS  port granted, transaction in flight
up_done  out  NPORTS  one-cycle completion pulse
down_rw_flag  out  2  request to memory_controller
down_addr  out  ADDR_W  latched address
down_write_data  out  DATA_W  latched write data
down_write_mask  out  DATA_W/8  latched mask
down_read_data  in  DATA_W  controller read data, valid with down_done
down_busy  in  1  controller cannot accept a new request
down_done  in  1  controller completion pulse

Behaviour:
- Reset (async, RST high): state IDLE; rr_ptr=0; all outputs 0, including up_read_data; cooldown mask 0.
- Request valid iff rw_flag is 01 or 10 and the port's cooldown bit is clear; 11 is ignored and never granted.
- IDLE: when any request is valid and down_busy=0, choose the first valid port at or after rr_ptr, wrapping modulo NPORTS.
  - Latch grant index, rw_flag, addr, write_data and mask.
  - Assert up_busy[grant]; go to ISSUE next cycle.
  - If down_busy=1, stay in IDLE without granting.
- ISSUE: drive down_rw_flag and the latched payload from registers. They are held stable until down_done. Go to WAIT.
- WAIT: hold down_* stable. On down_done:
  - up_done[grant]=1 for exactly one cycle.
  - up_read_data slice[grant] <= down_read_data (reads only; writes leave the slice unchanged).
  - up_busy[grant]=0; down_rw_flag=0.
  - rr_ptr <= grant+1 (wrap to 0 at NPORTS).
  - cooldown[grant] set for one cycle; state returns to IDLE.
- down_done outside WAIT is ignored.
- Cooldown: the client must drop rw_flag in the cycle after up_done. A request held longer is treated as a new request and re-arbitrated.
- Latency: request sampled in IDLE -> down_rw_flag asserted 2 cycles later. down_done -> up_done registered, 1 cycle later. Minimum back-to-back spacing on the downstream port is 3 cycles.
- Upstream rw_flag/addr changes after grant do not affect the in-flight transaction, because the payload is latched.
- NPORTS=1: rr_ptr is constant 0; behaviour is otherwise identical.
- Reset mid-transaction: everything returns to reset values immediately, with no done pulse. The downstream controller shares RST and is reset alongside.

Decomposition:
- Shared package/header: rw_flag encodings (RW_IDLE=2'b00, RW_READ=2'b01, RW_WRITE=2'b10) and state encodings IDLE/ISSUE/WAIT.
- One natural sub-module: rr_priority_pick (combinational), taking NPORTS request bits and rr_ptr and returning grant index plus a valid flag. It is reusable for a future generalised multchan_comm TX arbiter.

Test Plan:
1. Reset, then port0 read addr 0x00000010; controller returns 0xDEADBEEF after 3 cycles -> down_rw_flag=01 and down_addr=0x10 two cycles after request; up_done[0] one-cycle pulse; up_read_data[31:0]=0xDEADBEEF; up_read_data slice 1 still 0.
2. Ports 0 and 1 request simultaneously and hold continuously, rr_ptr=0 -> grants alternate 0,1,0,1 over 4 transactions; neither port is granted twice in a row while the other is requesting.
3. Port1 write addr 0x20, data 0x12345678, mask 4'b0011; upstream addr changed to 0x99 mid-flight -> down_addr stays 0x20 and down_write_mask stays 0011 until down_done; up_read_data[63:32] unchanged.
4. down_busy held 1 for 5 cycles while port0 requests -> no grant and down_rw_flag=00 throughout; grant occurs on the first cycle down_busy=0.
5. Port0 rw_flag=11 -> never granted, up_busy[0] stays 0. Stray down_done in IDLE -> no up_done pulse.
6. RST pulsed in WAIT state -> all outputs 0 asynchronously with no up_done; a fresh port1 read after reset completes normally, granted first because rr_ptr=0 and only port1 requests.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter: rw_flag encodings, arbiter
// state encoding and small helpers used by the top and the round-robin picker.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Width of a port index; a single-port build still needs a 1-bit vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // 2'b11 is deliberately not a request.
    function automatic logic rw_is_valid(input logic [1:0] f);
        return (f == RW_READ) || (f == RW_WRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker: returns the first asserted request at or
// after i_ptr, wrapping modulo NPORTS.
//   i_req   : NPORTS request bits
//   i_ptr   : starting index (highest priority)
//   o_idx   : chosen index (0 when none valid)
//   o_valid : at least one request asserted
// -----------------------------------------------------------------------------
module rr_priority_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    localparam int unsigned PTR_W = idx_width(NPORTS)
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [PTR_W-1:0]  o_idx,
    output logic              o_valid
);

    int unsigned w_pos;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= NPORTS) begin
                w_pos = w_pos - NPORTS;
            end
            if (!o_valid && i_req[w_pos[PTR_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Merges NPORTS core-side memory ports onto the single memory_controller port.
// Round-robin arbitration, one outstanding transaction, payload latched at grant.
//   CLK, RST          : clock, asynchronous active-high reset
//   up_rw_flag        : per-port request (01 read, 10 write, 00/11 idle)
//   up_addr/up_write_data/up_write_mask : per-port payload
//   up_read_data      : per-port read data, slice updated on that port's done
//   up_busy/up_done   : per-port in-flight flag / one-cycle completion pulse
//   down_*            : request and latched payload towards memory_controller
//   down_read_data/down_busy/down_done  : controller responses
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [2*NPORTS-1:0]           up_rw_flag,
    input  logic [ADDR_W*NPORTS-1:0]      up_addr,
    input  logic [DATA_W*NPORTS-1:0]      up_write_data,
    input  logic [(DATA_W/8)*NPORTS-1:0]  up_write_mask,
    output logic [DATA_W*NPORTS-1:0]      up_read_data,
    output logic [NPORTS-1:0]             up_busy,
    output logic [NPORTS-1:0]             up_done,
    output logic [1:0]                    down_rw_flag,
    output logic [ADDR_W-1:0]             down_addr,
    output logic [DATA_W-1:0]             down_write_data,
    output logic [DATA_W/8-1:0]           down_write_mask,
    input  logic [DATA_W-1:0]             down_read_data,
    input  logic                          down_busy,
    input  logic                          down_done
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned PTR_W  = idx_width(NPORTS);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_grant;
    logic [1:0]         r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [MASK_W-1:0]  r_mask;
    logic [1:0]         r_down_rw;
    logic [NPORTS-1:0]  r_up_busy;
    logic [NPORTS-1:0]  r_up_done;
    logic [NPORTS-1:0]  r_cooldown;

    logic [1:0]         w_rw    [NPORTS];
    logic [ADDR_W-1:0]  w_addr  [NPORTS];
    logic [DATA_W-1:0]  w_wdata [NPORTS];
    logic [MASK_W-1:0]  w_mask  [NPORTS];
    logic [NPORTS-1:0]  w_req;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic               w_grant_en;
    logic               w_done_en;
    logic [PTR_W-1:0]   w_ptr_nxt;

    // Per-port unpacking; read data lives in each port's own register so the
    // slices need no variable indexing.
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [DATA_W-1:0] r_rdata;

        assign w_rw[p]    = up_rw_flag[2*p +: 2];
        assign w_addr[p]  = up_addr[ADDR_W*p +: ADDR_W];
        assign w_wdata[p] = up_write_data[DATA_W*p +: DATA_W];
        assign w_mask[p]  = up_write_mask[MASK_W*p +: MASK_W];
        assign w_req[p]   = rw_is_valid(w_rw[p]) && !r_cooldown[p];
        assign up_read_data[DATA_W*p +: DATA_W] = r_rdata;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_rdata <= '0;
            end else if (w_done_en && (r_rw == RW_READ) && (r_grant == PTR_W'(p))) begin
                r_rdata <= down_read_data;
            end
        end
    end

    rr_priority_pick #(
        .NPORTS (NPORTS)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_ptr_nxt = (32'(r_grant) == NPORTS - 1) ? '0 : r_grant + PTR_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_done_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid && !down_busy) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (down_done) begin
                    w_done_en   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_rw       <= RW_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
            r_down_rw  <= RW_IDLE;
            r_up_busy  <= '0;
            r_up_done  <= '0;
            r_cooldown <= '0;
        end else begin
            r_up_done  <= '0;
            r_cooldown <= '0;
            if (w_grant_en) begin
                r_grant               <= w_pick_idx;
                r_rw                  <= w_rw[w_pick_idx];
                r_addr                <= w_addr[w_pick_idx];
                r_wdata               <= w_wdata[w_pick_idx];
                r_mask                <= w_mask[w_pick_idx];
                r_up_busy[w_pick_idx] <= 1'b1;
            end
            if (r_state == ST_ISSUE) begin
                r_down_rw <= r_rw;
            end
            // Cooldown blocks the finished port for the cycle after done so a
            // client dropping its flag late is not granted twice.
            if (w_done_en) begin
                r_up_done[r_grant]  <= 1'b1;
                r_cooldown[r_grant] <= 1'b1;
                r_up_busy           <= '0;
                r_down_rw           <= RW_IDLE;
                r_ptr               <= w_ptr_nxt;
            end
        end
    end

    assign up_busy         = r_up_busy;
    assign up_done         = r_up_done;
    assign down_rw_flag    = r_down_rw;
    assign down_addr       = r_addr;
    assign down_write_data = r_wdata;
    assign down_write_mask = r_mask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  up_rw_flag;
    logic [63:0] up_addr;
    logic [63:0] up_write_data;
    logic [7:0]  up_write_mask;
    logic [63:0] up_read_data;
    logic [1:0]  up_busy;
    logic [1:0]  up_done;
    logic [1:0]  down_rw_flag;
    logic [31:0] down_addr;
    logic [31:0] down_write_data;
    logic [3:0]  down_write_mask;
    logic [31:0] down_read_data;
    logic        down_busy;
    logic        down_done;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .NPORTS (2),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .up_rw_flag      (up_rw_flag),
        .up_addr         (up_addr),
        .up_write_data   (up_write_data),
        .up_write_mask   (up_write_mask),
        .up_read_data    (up_read_data),
        .up_busy         (up_busy),
        .up_done         (up_done),
        .down_rw_flag    (down_rw_flag),
        .down_addr       (down_addr),
        .down_write_data (down_write_data),
        .down_write_mask (down_write_mask),
        .down_read_data  (down_read_data),
        .down_busy       (down_busy),
        .down_done       (down_done)
    );

    typedef struct {
        logic [1:0]  rw0;
        logic [1:0]  rw1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [3:0]  mk0;
        logic [3:0]  mk1;
        logic [31:0] ctrl_rd;
        int          exp_port;
        logic [1:0]  exp_rw;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [3:0]  exp_mk;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] onehot(input int p);
        return 64'(1) << p;
    endfunction

    task automatic set_port(input int p, input logic [1:0] rw, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] mk);
        up_rw_flag[2*p +: 2]     = rw;
        up_addr[32*p +: 32]      = a;
        up_write_data[32*p +: 32] = wd;
        up_write_mask[4*p +: 4]  = mk;
    endtask

    task automatic idle_all();
        up_rw_flag    = '0;
        up_addr       = '0;
        up_write_data = '0;
        up_write_mask = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input int port);
        int n = 0;
        while (up_busy == 2'b00 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_grant"}, 64'(up_busy), onehot(port));
    endtask

    // From a granted state: wait for the downstream request, answer with done,
    // check the completion pulse and the port's read-data slice.
    task automatic complete(input string tag, input int port, input logic [31:0] rdata,
                            input logic [31:0] exp_slice, input bit drop);
        int n = 0;
        while (down_rw_flag == 2'b00 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_issued"}, 64'(down_rw_flag != 2'b00), 64'(1));
        @(negedge CLK);
        down_done      = 1'b1;
        down_read_data = rdata;
        @(negedge CLK);
        down_done      = 1'b0;
        down_read_data = '0;
        check({tag, "_done"}, 64'(up_done), onehot(port));
        check({tag, "_slice"}, 64'(up_read_data[32*port +: 32]), 64'(exp_slice));
        if (drop) idle_all();
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string t;
        t = $sformatf("v%0d", n);
        @(negedge CLK);
        set_port(0, v.rw0, v.addr0, v.wd0, v.mk0);
        set_port(1, v.rw1, v.addr1, v.wd1, v.mk1);
        @(negedge CLK);
        check({t, "_busy"}, 64'(up_busy), onehot(v.exp_port));
        check({t, "_rw_not_yet"}, 64'(down_rw_flag), 64'(0));
        @(negedge CLK);
        check({t, "_down_rw"}, 64'(down_rw_flag), 64'(v.exp_rw));
        check({t, "_down_addr"}, 64'(down_addr), 64'(v.exp_addr));
        check({t, "_down_wdata"}, 64'(down_write_data), 64'(v.exp_wd));
        check({t, "_down_mask"}, 64'(down_write_mask), 64'(v.exp_mk));
        repeat (2) @(negedge CLK);
        check({t, "_hold_rw"}, 64'(down_rw_flag), 64'(v.exp_rw));
        down_done      = 1'b1;
        down_read_data = v.ctrl_rd;
        @(negedge CLK);
        down_done      = 1'b0;
        down_read_data = '0;
        check({t, "_done"}, 64'(up_done), onehot(v.exp_port));
        check({t, "_busy_clr"}, 64'(up_busy), 64'(0));
        check({t, "_rw_clr"}, 64'(down_rw_flag), 64'(0));
        check({t, "_rd0"}, 64'(up_read_data[31:0]), 64'(v.exp_rd0));
        check({t, "_rd1"}, 64'(up_read_data[63:32]), 64'(v.exp_rd1));
        idle_all();
        @(negedge CLK);
        check({t, "_done_pulse"}, 64'(up_done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rr_ptr evolves 0 ->1 ->0 ->1 ->0 ->0 ->0 ->1 across these vectors.
        vecs[0] = '{2'b01, 2'b00, 32'h10, 32'h0,  32'h0, 32'h0, 4'h0, 4'h0, 32'hDEADBEEF,
                    0, 2'b01, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{2'b00, 2'b10, 32'h0,  32'h20, 32'h0, 32'h12345678, 4'h0, 4'h3, 32'hBAD0BAD0,
                    1, 2'b10, 32'h20, 32'h12345678, 4'h3, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{2'b01, 2'b01, 32'h30, 32'h40, 32'h0, 32'h0, 4'hF, 4'hF, 32'h0A0A0A0A,
                    0, 2'b01, 32'h30, 32'h0, 4'hF, 32'h0A0A0A0A, 32'h0};
        vecs[3] = '{2'b01, 2'b01, 32'h50, 32'h60, 32'h0, 32'h0, 4'hF, 4'hF, 32'h11112222,
                    1, 2'b01, 32'h60, 32'h0, 4'hF, 32'h0A0A0A0A, 32'h11112222};
        vecs[4] = '{2'b00, 2'b10, 32'h0,  32'h70, 32'h0, 32'hCAFEF00D, 4'h0, 4'h1, 32'h55555555,
                    1, 2'b10, 32'h70, 32'hCAFEF00D, 4'h1, 32'h0A0A0A0A, 32'h11112222};
        vecs[5] = '{2'b11, 2'b01, 32'hA5, 32'h80, 32'h0, 32'h0, 4'h0, 4'hF, 32'h33334444,
                    1, 2'b01, 32'h80, 32'h0, 4'hF, 32'h0A0A0A0A, 32'h33334444};
        vecs[6] = '{2'b10, 2'b01, 32'h90, 32'h94, 32'h0BADCAFE, 32'h0, 4'hC, 4'hF, 32'h77777777,
                    0, 2'b10, 32'h90, 32'h0BADCAFE, 4'hC, 32'h0A0A0A0A, 32'h33334444};

        RST            = 1'b1;
        down_busy      = 1'b0;
        down_done      = 1'b0;
        down_read_data = '0;
        idle_all();
        repeat (2) @(negedge CLK);
        check("rst_busy", 64'(up_busy), 64'(0));
        check("rst_done", 64'(up_done), 64'(0));
        check("rst_down_rw", 64'(down_rw_flag), 64'(0));
        check("rst_down_addr", 64'(down_addr), 64'(0));
        check("rst_rdata", up_read_data, 64'(0));
        RST = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Continuous requests from both ports after reset: grants alternate 0,1,0,1.
        do_reset();
        @(negedge CLK);
        set_port(0, 2'b01, 32'h100, 32'h0, 4'hF);
        set_port(1, 2'b01, 32'h200, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            wait_grant($sformatf("alt%0d", i), i % 2);
            complete($sformatf("alt%0d", i), i % 2, 32'hA0000000 + 32'(i),
                     32'hA0000000 + 32'(i), i == 3);
        end

        // Write from port1 with upstream payload changed after grant.
        @(negedge CLK);
        set_port(1, 2'b10, 32'h20, 32'h12345678, 4'h3);
        wait_grant("mid", 1);
        set_port(1, 2'b10, 32'h99, 32'hFFFFFFFF, 4'hF);
        repeat (3) begin
            @(negedge CLK);
            check("mid_addr", 64'(down_addr), 64'h20);
            check("mid_mask", 64'(down_write_mask), 64'h3);
            check("mid_wdata", 64'(down_write_data), 64'h12345678);
        end
        down_done = 1'b1;
        @(negedge CLK);
        down_done = 1'b0;
        check("mid_done", 64'(up_done), 64'b10);
        check("mid_rd1_kept", 64'(up_read_data[63:32]), 64'hA0000003);
        check("mid_rw_clr", 64'(down_rw_flag), 64'(0));
        idle_all();

        // Controller busy for five cycles: no grant until it drops.
        @(negedge CLK);
        down_busy = 1'b1;
        set_port(0, 2'b01, 32'hA0, 32'h0, 4'hF);
        repeat (5) begin
            @(negedge CLK);
            check("dbusy_no_grant", 64'(up_busy), 64'(0));
            check("dbusy_no_req", 64'(down_rw_flag), 64'(0));
        end
        down_busy = 1'b0;
        @(negedge CLK);
        check("dbusy_grant", 64'(up_busy), 64'b01);
        complete("dbusy", 0, 32'h4444AAAA, 32'h4444AAAA, 1'b1);

        // rw_flag 11 is never granted; stray done in IDLE produces no pulse.
        @(negedge CLK);
        set_port(0, 2'b11, 32'hB0, 32'h0, 4'hF);
        repeat (3) begin
            @(negedge CLK);
            check("rw11_no_grant", 64'(up_busy), 64'(0));
        end
        down_done = 1'b1;
        down_read_data = 32'h5A5A5A5A;
        @(negedge CLK);
        down_done = 1'b0;
        down_read_data = '0;
        check("stray_no_done", 64'(up_done), 64'(0));
        check("stray_no_grant", 64'(up_busy), 64'(0));
        @(negedge CLK);
        check("stray_no_done2", 64'(up_done), 64'(0));
        check("stray_rd0_kept", 64'(up_read_data[31:0]), 64'h4444AAAA);
        idle_all();

        // Asynchronous reset while waiting on the controller.
        @(negedge CLK);
        set_port(0, 2'b01, 32'hC4, 32'h0, 4'hF);
        wait_grant("rstw", 0);
        @(negedge CLK);
        check("rstw_in_wait", 64'(down_rw_flag), 64'b01);
        #3 RST = 1'b1;
        #1;
        check("rstw_busy", 64'(up_busy), 64'(0));
        check("rstw_done", 64'(up_done), 64'(0));
        check("rstw_down_rw", 64'(down_rw_flag), 64'(0));
        check("rstw_down_addr", 64'(down_addr), 64'(0));
        check("rstw_rdata", up_read_data, 64'(0));
        idle_all();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rstw_no_done", 64'(up_done), 64'(0));
        set_port(1, 2'b01, 32'hC0, 32'h0, 4'hF);
        wait_grant("post_rst", 1);
        check("post_rst_addr_next", 64'(down_rw_flag), 64'(0));
        complete("post_rst", 1, 32'hC0C0C0C0, 32'hC0C0C0C0, 1'b1);
        check("post_rst_rd0", 64'(up_read_data[31:0]), 64'(0));
        @(negedge CLK);
        check("post_rst_done_pulse", 64'(up_done), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
